pwm_capture: RTL
================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the period and high-time counters and outputs.
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port capture_EN  input  1  measurement enable; low forces IDLE.
REQ-005 SHALL have port i_pwm  input  1  asynchronous PWM waveform under measurement.
REQ-006 SHALL have port o_period  output  CNT_W  last measured period in clk cycles.
REQ-007 SHALL have port o_duty  output  CNT_W  last measured high time in clk cycles.
REQ-008 SHALL have port o_valid  output  1  one-cycle pulse when o_period/o_duty update.
REQ-009 SHALL have port o_timeout  output  1  sticky flag: no complete period within counter range.

Function
REQ-010 SHALL pass i_pwm through a 2-flop synchroniser, then a registered edge detector; all counting uses the synchronised signal.
REQ-011 SHALL implement FSM states IDLE, HIGH, LOW.
REQ-012 IDLE: counters held at 0; first detected rising edge -> HIGH; a first falling edge SHALL be ignored (no partial period measured).
REQ-013 HIGH: high and period counters increment each cycle; falling edge -> LOW.
REQ-014 LOW: period counter increments, high counter holds; rising edge -> latch results, pulse o_valid, restart both counters at 1, -> HIGH.
REQ-015 Counting SHALL be such that a waveform with period P cycles and high time H cycles (1 <= H < P) yields o_period = P, o_duty = H exactly.
REQ-016 o_valid SHALL assert exactly 3 clk cycles after the first clk edge that samples i_pwm high at the pin, for each rising edge ending a period.
REQ-017 o_period/o_duty SHALL change only in the cycle o_valid is high; otherwise hold.
REQ-018 If the period counter would exceed 2^CNT_W-1 in HIGH or LOW (0% or 100% duty, or period too long), SHALL set o_timeout, return to IDLE, no o_valid, outputs hold.
REQ-019 o_timeout SHALL clear in the cycle of the next o_valid pulse, or on reset.
REQ-020 capture_EN low SHALL, on the next clock, force IDLE and clear counters; o_period/o_duty/o_timeout hold; o_valid low; a measurement in progress is discarded.
REQ-021 capture_EN rising SHALL restart from IDLE; first o_valid only after two rising edges.
REQ-022 A rising edge coincident with counter saturation SHALL be treated as timeout (timeout wins).

Reset
REQ-023 rst high SHALL asynchronously clear synchroniser, edge detector, counters, FSM (IDLE), o_period=0, o_duty=0, o_valid=0, o_timeout=0.
REQ-024 Reset mid-measurement SHALL discard the partial period; after release, behaviour is as REQ-012.

Configuration
REQ-025 Macro PWM_CAPTURE_GLITCH_FILTER_EN, when defined, SHALL insert a 3-sample majority filter after the synchroniser: pulses of 1 clk cycle are rejected, and REQ-016 latency becomes 5 cycles.
REQ-026 Without PWM_CAPTURE_GLITCH_FILTER_EN, no filter; every synchronised edge is counted; latency 3 cycles.

Verification
REQ-027 rst then capture_EN=1, i_pwm period 100 / high 25 cycles -> o_valid once per 100 cycles, o_period=100, o_duty=25; o_timeout=0.
REQ-028 Switch waveform to period 200 / high 100 mid-run -> at most one mismatched sample, then o_period=200, o_duty=100 stable.
REQ-029 i_pwm held high (100% duty) with CNT_W=8 -> o_timeout=1 after <=258 cycles, no o_valid; then resume period 20/high 15 -> o_valid with 20/15, o_timeout cleared.
REQ-030 capture_EN=0 for 200 cycles mid-period -> no o_valid, outputs hold; re-enable -> first o_valid after second rising edge, correct values.
REQ-031 Assert rst in LOW state -> all outputs 0 immediately (asynchronously); after release, period 100/high 60 measured correctly.
REQ-032 With PWM_CAPTURE_GLITCH_FILTER_EN, 1-cycle glitch inside a 100/25 waveform -> values unchanged at 100/25; without macro -> a corrupted measurement is reported.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM period / high-time capture: synchronised input, edge detection, IDLE/HIGH/LOW measurement FSM.
// Define PWM_CAPTURE_GLITCH_FILTER_EN to add a 3-sample majority filter (adds 2 cycles of latency).
module pwm_capture #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_EN,
    input  logic             i_pwm,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_duty,
    output logic             o_valid,
    output logic             o_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic sync1_q, sync2_q;
    logic pwm_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= i_pwm;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic tap1_q, tap2_q, filt_q;
    logic filt_d;

    // Majority over three consecutive synchronised samples rejects single-cycle pulses.
    always_comb begin
        filt_d = (sync2_q & tap1_q) | (sync2_q & tap2_q) | (tap1_q & tap2_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tap1_q <= 1'b0;
            tap2_q <= 1'b0;
            filt_q <= 1'b0;
        end else begin
            tap1_q <= sync2_q;
            tap2_q <= tap1_q;
            filt_q <= filt_d;
        end
    end

    assign pwm_s = filt_q;
`else
    assign pwm_s = sync2_q;
`endif

    logic prev_q, rise_q, fall_q;
    logic rise_d, fall_d;

    always_comb begin
        rise_d = pwm_s & ~prev_q;
        fall_d = ~pwm_s & prev_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= pwm_s;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] period_out_q, period_out_d;
    logic [CNT_W-1:0] duty_out_q, duty_out_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        period_out_d = period_out_q;
        duty_out_d   = duty_out_q;
        valid_d      = 1'b0;
        timeout_d    = timeout_q;

        if (!capture_EN) begin
            state_d      = IDLE;
            period_cnt_d = CNT_ZERO;
            high_cnt_d   = CNT_ZERO;
        end else begin
            unique case (state_q)
                IDLE: begin
                    period_cnt_d = CNT_ZERO;
                    high_cnt_d   = CNT_ZERO;
                    if (rise_q) begin
                        state_d      = HIGH;
                        period_cnt_d = CNT_ONE;
                        high_cnt_d   = CNT_ONE;
                    end
                end
                HIGH: begin
                    // Saturation is checked first so it overrides any coincident edge.
                    if (period_cnt_q == CNT_MAX) begin
                        state_d      = IDLE;
                        timeout_d    = 1'b1;
                        period_cnt_d = CNT_ZERO;
                        high_cnt_d   = CNT_ZERO;
                    end else if (fall_q) begin
                        state_d      = LOW;
                        period_cnt_d = period_cnt_q + CNT_ONE;
                    end else begin
                        period_cnt_d = period_cnt_q + CNT_ONE;
                        high_cnt_d   = high_cnt_q + CNT_ONE;
                    end
                end
                LOW: begin
                    if (period_cnt_q == CNT_MAX) begin
                        state_d      = IDLE;
                        timeout_d    = 1'b1;
                        period_cnt_d = CNT_ZERO;
                        high_cnt_d   = CNT_ZERO;
                    end else if (rise_q) begin
                        state_d      = HIGH;
                        period_out_d = period_cnt_q;
                        duty_out_d   = high_cnt_q;
                        valid_d      = 1'b1;
                        timeout_d    = 1'b0;
                        period_cnt_d = CNT_ONE;
                        high_cnt_d   = CNT_ONE;
                    end else begin
                        period_cnt_d = period_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d      = IDLE;
                    period_cnt_d = CNT_ZERO;
                    high_cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            period_cnt_q <= CNT_ZERO;
            high_cnt_q   <= CNT_ZERO;
            period_out_q <= CNT_ZERO;
            duty_out_q   <= CNT_ZERO;
            valid_q      <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            period_out_q <= period_out_d;
            duty_out_q   <= duty_out_d;
            valid_q      <= valid_d;
            timeout_q    <= timeout_d;
        end
    end

    assign o_period  = period_out_q;
    assign o_duty    = duty_out_q;
    assign o_valid   = valid_q;
    assign o_timeout = timeout_q;

endmodule
